// File: rtl/pic16f84_fetch_ctrl.sv
// pic16f84_fetch_ctrl: Q1..Q4 phase generator, 13-bit program counter,
// 8-level circular return stack and fetch/execute instruction register.
// Optional macro FETCH_STACK_FLAGS_EN adds sticky stack_ovf / stack_unf
// outputs backed by a saturating depth counter.
module pic16f84_fetch_ctrl #(
    parameter int              PC_W        = 13,
    parameter int              INST_W      = 14,
    parameter int              STACK_DEPTH = 8,
    parameter logic [PC_W-1:0] RESET_VEC   = 13'h000
) (
    input  logic              clk,
    input  logic              mclr_n,
    input  logic [INST_W-1:0] rom_inst,
    input  logic              jump,
    input  logic              call,
    input  logic [PC_W-1:0]   jump_addr,
    input  logic              ret,
    input  logic              pc_write,
    input  logic [PC_W-1:0]   pc_wdata,
    input  logic              skip,
    output logic              q1,
    output logic              q2,
    output logic              q3,
    output logic              q4,
    output logic [PC_W-1:0]   rom_addr,
    output logic [INST_W-1:0] ir,
    output logic              inst_valid
`ifdef FETCH_STACK_FLAGS_EN
    ,
    output logic              stack_ovf,
    output logic              stack_unf
`endif
);

    localparam int SP_W = $clog2(STACK_DEPTH);

    logic [1:0]      phase;
    logic            running;
    logic [PC_W-1:0] pc;
    logic [SP_W-1:0] sp;
    logic [SP_W-1:0] sp_prev;
    logic [PC_W-1:0] stack [STACK_DEPTH];
    logic            update;
    logic            any_change;
    logic            push;
    logic            pop;

    // The reset phase is 3 so the first edge lands on Q1; 'running' keeps that
    // first 3->0 edge from being an update edge, so cycle 1 executes a NOP.
    assign update     = running && (phase == 2'd3);
    assign any_change = ret | jump | pc_write | skip;
    assign pop        = update && ret;
    assign push       = update && !ret && jump && call;
    assign sp_prev    = sp - 1'b1;
    assign rom_addr   = pc;

    // Phase counter and registered one-hot decode of the upcoming phase
    always_ff @(posedge clk or negedge mclr_n) begin
        if (!mclr_n) begin
            phase   <= 2'd3;
            running <= 1'b0;
            q1      <= 1'b0;
            q2      <= 1'b0;
            q3      <= 1'b0;
            q4      <= 1'b0;
        end else begin
            phase   <= phase + 2'd1;
            running <= 1'b1;
            q1      <= (phase == 2'd3);
            q2      <= (phase == 2'd0);
            q3      <= (phase == 2'd1);
            q4      <= (phase == 2'd2);
        end
    end

    // PC, stack pointer and IR advance only on the Q4->Q1 edge;
    // any PC discontinuity replaces the prefetched word with a NOP
    always_ff @(posedge clk or negedge mclr_n) begin
        if (!mclr_n) begin
            pc         <= RESET_VEC;
            sp         <= '0;
            ir         <= '0;
            inst_valid <= 1'b0;
        end else if (update) begin
            if (ret) begin
                pc <= stack[sp_prev];
                sp <= sp_prev;
            end else if (jump) begin
                pc <= jump_addr;
                if (call) sp <= sp + 1'b1;
            end else if (pc_write) begin
                pc <= pc_wdata;
            end else begin
                pc <= pc + 1'b1;
            end
            ir         <= any_change ? '0 : rom_inst;
            inst_valid <= ~any_change;
        end
    end

    // Return stack storage: not cleared by reset, overwrites circularly
    always_ff @(posedge clk) begin
        if (push) stack[sp] <= pc;
    end

`ifdef FETCH_STACK_FLAGS_EN
    localparam logic [SP_W:0] DEPTH_MAX = (SP_W+1)'(STACK_DEPTH);

    logic [SP_W:0] depth;

    // Saturating occupancy count with sticky overflow/underflow flags
    always_ff @(posedge clk or negedge mclr_n) begin
        if (!mclr_n) begin
            depth     <= '0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else if (pop) begin
            if (depth == '0) stack_unf <= 1'b1;
            else             depth     <= depth - 1'b1;
        end else if (push) begin
            if (depth == DEPTH_MAX) stack_ovf <= 1'b1;
            else                    depth     <= depth + 1'b1;
        end
    end
`else
    // Without the flags there is no occupancy tracking; sp simply wraps.
`endif

endmodule

// File: tb/tb_pic16f84_fetch_ctrl.sv
// Directed bench for pic16f84_fetch_ctrl: sequential fetch, jump, call/ret,
// skip, PC wrap, pc_write, priority, 9-deep stack wrap and mid-cycle reset.
module tb_pic16f84_fetch_ctrl;

    logic        clk = 1'b0;
    logic        mclr_n;
    logic [13:0] rom_inst;
    logic        jump, call, ret, pc_write, skip;
    logic [12:0] jump_addr, pc_wdata;
    logic        q1, q2, q3, q4;
    logic [12:0] rom_addr;
    logic [13:0] ir;
    logic        inst_valid;
`ifdef FETCH_STACK_FLAGS_EN
    logic        stack_ovf, stack_unf;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // ROM model: every address holds a distinct non-NOP word
    function automatic logic [13:0] word(input logic [12:0] a);
        return {1'b1, a};
    endfunction
    assign rom_inst = word(rom_addr);

    pic16f84_fetch_ctrl dut (
        .clk(clk), .mclr_n(mclr_n), .rom_inst(rom_inst),
        .jump(jump), .call(call), .jump_addr(jump_addr), .ret(ret),
        .pc_write(pc_write), .pc_wdata(pc_wdata), .skip(skip),
        .q1(q1), .q2(q2), .q3(q3), .q4(q4),
        .rom_addr(rom_addr), .ir(ir), .inst_valid(inst_valid)
`ifdef FETCH_STACK_FLAGS_EN
        , .stack_ovf(stack_ovf), .stack_unf(stack_unf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // advance one full instruction cycle, land just after the next Q1 edge
    task automatic cyc();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        jump = 0; call = 0; ret = 0; pc_write = 0; skip = 0;
    endtask

    // one-cycle control pulse, then clear
    task automatic pulse_jump(input logic [12:0] a, input logic c);
        jump = 1; call = c; jump_addr = a;
        cyc();
        clr();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mclr_n = 0; clr(); jump_addr = '0; pc_wdata = '0;
        #22;
        chk("rst_q", {q1, q2, q3, q4}, 4'b0000);
        chk("rst_addr", rom_addr, 13'h000);
        chk("rst_ir", ir, 14'h0000);
        chk("rst_iv", inst_valid, 1'b0);
        #1 mclr_n = 1;

        // cycle 1: NOP at address 0, then phase rotation
        @(posedge clk); #1;
        chk("c1_q", {q1, q2, q3, q4}, 4'b1000);
        chk("c1_addr", rom_addr, 13'h000);
        chk("c1_ir", ir, 14'h0000);
        chk("c1_iv", inst_valid, 1'b0);
        @(posedge clk); #1; chk("q2", {q1, q2, q3, q4}, 4'b0100);
        @(posedge clk); #1; chk("q3", {q1, q2, q3, q4}, 4'b0010);
        @(posedge clk); #1; chk("q4", {q1, q2, q3, q4}, 4'b0001);
        @(posedge clk); #1;
        chk("c2_q", {q1, q2, q3, q4}, 4'b1000);
        chk("c2_addr", rom_addr, 13'h001);
        chk("c2_ir", ir, word(13'h000));
        chk("c2_iv", inst_valid, 1'b1);
        cyc();
        chk("c3_addr", rom_addr, 13'h002);
        chk("c3_ir", ir, word(13'h001));
        repeat (4) cyc();
        chk("c7_ir", ir, word(13'h005));

        // jump while executing address 5
        pulse_jump(13'h123, 0);
        chk("jmp_ir", ir, 14'h0000);
        chk("jmp_iv", inst_valid, 1'b0);
        chk("jmp_addr", rom_addr, 13'h123);
        cyc();
        chk("jmp_tgt_ir", ir, word(13'h123));
        chk("jmp_tgt_iv", inst_valid, 1'b1);

        // CALL at 0x010 to 0x040, RET at 0x041
        pulse_jump(13'h010, 0); cyc();
        chk("call_src", ir, word(13'h010));
        pulse_jump(13'h040, 1);
        chk("call_ir", ir, 14'h0000);
        chk("call_addr", rom_addr, 13'h040);
        cyc(); cyc();
        chk("ret_src", ir, word(13'h041));
        ret = 1; cyc(); clr();
        chk("ret_ir", ir, 14'h0000);
        chk("ret_addr", rom_addr, 13'h011);
        cyc();
        chk("ret_exec", ir, word(13'h011));

        // skip while executing address 7
        pulse_jump(13'h007, 0); cyc();
        chk("skip_src", ir, word(13'h007));
        skip = 1; cyc(); clr();
        chk("skip_ir", ir, 14'h0000);
        chk("skip_iv", inst_valid, 1'b0);
        cyc();
        chk("skip_exec", ir, word(13'h009));

        // PC increment wraps at the top of program memory
        pulse_jump(13'h1FFF, 0); cyc();
        chk("wrap_ir", ir, word(13'h1FFF));
        chk("wrap_addr", rom_addr, 13'h0000);

        // jump beats pc_write
        jump = 1; jump_addr = 13'h300; pc_write = 1; pc_wdata = 13'h222;
        cyc(); clr();
        chk("prio_jw", rom_addr, 13'h300);
        cyc();
        pc_write = 1; pc_wdata = 13'h222; cyc(); clr();
        chk("pcw_addr", rom_addr, 13'h222);
        chk("pcw_ir", ir, 14'h0000);
        cyc();
        chk("pcw_exec", ir, word(13'h222));

        // call without jump is ignored
        call = 1; cyc(); clr();
        chk("calln_addr", rom_addr, 13'h224);
        chk("calln_ir", ir, word(13'h223));

        // nine nested calls: pushes F1, 101, 111, ... 171 (171 lands on entry 0)
        pulse_jump(13'h0F0, 0); cyc();
        for (int i = 0; i < 9; i++) begin
            pulse_jump(13'(13'h100 + 13'h010 * i), 1);
            chk("nest_call", rom_addr, 32'(13'h100 + 13'h010 * i));
            cyc();
        end
`ifdef FETCH_STACK_FLAGS_EN
        chk("ovf_set", stack_ovf, 1'b1);
        chk("unf_clr", stack_unf, 1'b0);
`endif
        for (int j = 0; j < 9; j++) begin
            ret = 1; cyc(); clr();
            chk("nest_ret", rom_addr, (j < 8) ? 32'(13'h171 - 13'h010 * j) : 32'h171);
            cyc();
        end
`ifdef FETCH_STACK_FLAGS_EN
        chk("unf_set", stack_unf, 1'b1);
`endif
        // ret wins over jump; empty-stack pop reads entry 7
        ret = 1; jump = 1; jump_addr = 13'h055; cyc(); clr();
        chk("prio_rj", rom_addr, 13'h161);
        cyc();

        // reset during q3 of a jump cycle
        jump = 1; jump_addr = 13'h0AA;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_q3", {q1, q2, q3, q4}, 4'b0010);
        #1 mclr_n = 0;
        #1;
        chk("mid_q", {q1, q2, q3, q4}, 4'b0000);
        chk("mid_addr", rom_addr, 13'h000);
        chk("mid_ir", ir, 14'h0000);
        chk("mid_iv", inst_valid, 1'b0);
`ifdef FETCH_STACK_FLAGS_EN
        chk("mid_flags", {stack_ovf, stack_unf}, 2'b00);
`endif
        clr();
        #2 mclr_n = 1;
        @(posedge clk); #1;
        chk("rs_q", {q1, q2, q3, q4}, 4'b1000);
        chk("rs_addr", rom_addr, 13'h000);
        chk("rs_iv", inst_valid, 1'b0);
        cyc();
        chk("rs_addr2", rom_addr, 13'h001);
        chk("rs_ir2", ir, word(13'h000));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pic16f84_fetch_ctrl.md
Name: pic16f84_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the PIC16F84 core.
- Divides the oscillator into Q1..Q4 phases, owns the 13-bit program counter and the 8-level hardware return stack, and drives the program-ROM address.
- Captures the fetched word into the instruction register (IR) and inserts a NOP flush on every PC discontinuity (two-stage fetch/execute pipeline).
- Sits between the program ROM and the execute/decode unit.

Parameters:
- PC_W, 13, program counter and ROM address width
- INST_W, 14, instruction word width
- STACK_DEPTH, 8, return-stack entries (power of 2)
- RESET_VEC, 13'h000, PC value after reset

Ports:
- clk  in  1  oscillator clock (one Q phase per rising edge)
- mclr_n  in  1  asynchronous active-low reset (MCLR)
- rom_inst  in  INST_W  word read from ROM at rom_addr
- jump  in  1  GOTO/CALL taken; target on jump_addr
- call  in  1  qualifies jump: push return address
- jump_addr  in  PC_W  jump target
- ret  in  1  RETURN/RETLW/RETFIE: pop stack into PC
- pc_write  in  1  computed PC write (PCL destination)
- pc_wdata  in  PC_W  value for pc_write
- skip  in  1  conditional skip taken (BTFSx/DECFSZ/INCFSZ)
- q1, q2, q3, q4  out  1 each  one-hot phase strobes; q1 also feeds ROM
- rom_addr  out  PC_W  current PC
- ir  out  INST_W  instruction executing this cycle
- inst_valid  out  1  0 when ir holds a flush/reset NOP

Behaviour:
- Reset (mclr_n low, asynchronous):
  - phase counter = 3
  - q1..q4 = 0
  - pc = RESET_VEC
  - ir = 14'h0000
  - inst_valid = 0
  - sp = 0
  - Stack RAM contents are not cleared.
- Phase sequencing:
  - Each rising edge advances phase modulo 4; q1..q4 are registered decodes of the new phase.
  - The first edge after reset release gives q1 = 1.
  - Exactly one q output is high whenever running.
- Instruction cycle = 4 clk. The only update edge is the Q4->Q1 edge (phase 3 -> 0). All control inputs are sampled there; they are ignored on the other three edges.
- At the update edge, with PC-change priority ret > jump > pc_write > skip > none:
  - ret: pc <= stack[sp-1]; sp <= sp-1.
  - jump: pc <= jump_addr; if call, also stack[sp] <= pc and sp <= sp+1.
  - pc_write: pc <= pc_wdata.
  - skip: pc <= pc+1.
  - none: pc <= pc+1.
  - ir <= any_change ? 14'h0000 : rom_inst, where any_change = ret|jump|pc_write|skip.
  - inst_valid <= ~any_change.
- Latency and flush:
  - The word fetched during cycle N executes in cycle N+1.
  - A taken branch costs 2 cycles: the discarded word becomes a NOP, then the target is fetched.
- First cycle after reset executes a NOP (ir = 0, inst_valid = 0); ROM address 0 executes in cycle 2.
- Return address: pc during execution of address A is A+1, so CALL pushes A+1.
- PC wraps 13'h1FFF -> 13'h0000 on increment.
- Stack wrap and boundaries:
  - sp is log2(STACK_DEPTH) bits and wraps circularly.
  - The 9th push overwrites entry 0 silently.
  - Pop on an empty stack wraps to entry 7 and returns whatever is stored there.
- call without jump: ignored.
- ret with jump: ret wins; no push.
- Reset asserted mid-cycle: immediate clear; the cycle restarts from Q1 after release.

Optional Feature:
- Macro: FETCH_STACK_FLAGS_EN.
- Defined: adds outputs stack_ovf and stack_unf (1 bit each, sticky, cleared only by mclr_n).
  - stack_ovf sets on a push when depth count == STACK_DEPTH.
  - stack_unf sets on a pop when depth count == 0.
  - A depth counter of 0..STACK_DEPTH saturates at both ends.
- Not defined: no flag ports and no depth counter; wrap behaviour is unchanged.

Test Plan:
- Reset release, rom_inst = address-encoded words, no controls -> q1..q4 rotate with period 4 clk; rom_addr 0,1,2,3 per cycle; ir = NOP, then word(0), word(1); inst_valid 0,1,1.
- jump = 1, jump_addr = 13'h0123 while executing address 5 -> next ir = NOP with inst_valid = 0; rom_addr = 0x123; the cycle after, ir = word(0x123).
- CALL at address 0x010 to 0x040, then ret at 0x041 -> stack holds 0x011; pc returns to 0x011; two NOP flushes total.
- skip = 1 while executing address 7 -> word(8) replaced by NOP; next executed word(9).
- 9 nested CALLs then 9 RETs -> the 9th RET returns the 1st pushed address overwritten by the 9th; with FETCH_STACK_FLAGS_EN, stack_ovf = 1 after the 9th call and stack_unf = 0.
- mclr_n pulsed low during q3 of a jump cycle -> outputs clear immediately; no jump taken; restart fetch at 13'h000.
